alu_arb_ctrl: RTL and testbench
===============================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter: ALU_LAT, default 1, cycles the registered ALU inputs are held before alu_out is sampled (legal 1..4).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Ports: req0_valid, req1_valid  input  1 each  requester n has an operation pending.
REQ-005 Ports: req0_ready, req1_ready  output  1 each  requester n accepted this cycle (single-cycle pulse).
REQ-006 Ports: req0_op, req1_op  input  2 each; req0_a, req0_b, req1_a, req1_b  input  4 each  operation code and operands.
REQ-007 Ports: alu_op  output  2; alu_a, alu_b  output  4 each; alu_out  input  4  connection to the shared combinational ALU.
REQ-008 Ports: rsp_valid  output  1; rsp_ready  input  1; rsp_data  output  4; rsp_id  output  1 (winning requester index).
REQ-009 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-010 FSM states SHALL be IDLE, EXEC, RESP; encoding in the shared package.
REQ-011 In IDLE with at least one reqN_valid, the controller SHALL pulse the winner's reqN_ready for exactly that cycle, register its op/a/b and index, and enter EXEC next cycle.
REQ-012 Arbitration SHALL be round-robin: a single requester valid wins; both valid -> the requester not granted last wins.
REQ-013 A requester SHALL hold valid and operands stable until its ready pulse; the controller samples operands only on the accept cycle.
REQ-014 alu_op/alu_a/alu_b SHALL drive the registered values from the cycle after acceptance until the next acceptance; otherwise they hold their last value.
REQ-015 EXEC SHALL last exactly ALU_LAT cycles (down-counter); on its last cycle alu_out SHALL be captured into rsp_data and the FSM SHALL enter RESP.
REQ-016 In RESP, rsp_valid SHALL be 1 with rsp_data/rsp_id stable until the cycle rsp_ready=1, after which the FSM returns to IDLE and rsp_valid drops.
REQ-017 Latency: rsp_valid SHALL rise ALU_LAT+1 cycles after the accept cycle; with rsp_ready tied high, accepts occur at most every ALU_LAT+2 cycles.
REQ-018 No request SHALL be accepted outside IDLE; reqN_ready SHALL be 0 in EXEC and RESP.
REQ-019 rsp_data SHALL be the 4-bit alu_out unmodified; the controller is op-agnostic.

Reset
REQ-020 While rst=1: state=IDLE, reqN_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, alu_op/alu_a/alu_b=0, busy=0, EXEC counter=0, last-grant=1 (requester 0 wins first contention).
REQ-021 rst asserted in EXEC or RESP SHALL abandon the transaction with no response produced.

Configuration
REQ-022 Macro ALU_ARB_CTRL_STATS_EN: when defined, outputs grant_cnt0 and grant_cnt1 (8 bits each) SHALL count accepts per requester, saturating at 255, cleared by rst; when undefined these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-023 Package alu_pkg SHALL hold ALU_OP_W=2, ALU_DATA_W=4 and the FSM state enum.
REQ-024 Round-robin selection SHALL be a sub-module rr_arb2 (inputs two requests and last-grant, outputs one-hot grant); all else lives in alu_arb_ctrl.

Verification
REQ-025 Single request: ALU_LAT=1, req0 op=2'b00 a=4'h3 b=4'h4, rsp_ready=1 -> req0_ready pulse at T, alu_a=3/alu_b=4 at T+1, rsp_valid at T+2, rsp_data=alu model result, rsp_id=0.
REQ-026 Contention: both valid from reset -> req0 granted first, req1 granted at next IDLE; third simultaneous round -> req0 again.
REQ-027 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable for all 5, no reqN_ready pulses, busy=1.
REQ-028 Latency sweep: ALU_LAT=4 -> rsp_valid exactly 5 cycles after accept; rsp_data equals alu_out sampled on last EXEC cycle.
REQ-029 Reset mid-EXEC: assert rst one cycle into EXEC -> next cycle all outputs at reset values, no rsp_valid; following req1 request completes normally.
REQ-030 With ALU_ARB_CTRL_STATS_EN: 300 consecutive req0-only transactions -> grant_cnt0=255, grant_cnt1=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and FSM state encoding for the two-requester ALU arbiter.
package alu_pkg;
  localparam int ALU_OP_W   = 2;
  localparam int ALU_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arb_ctrl_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whichever requester was not granted last (last_grant holds that index).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU and returns the
// result through a valid/ready response port. Optional per-requester grant
// counters are built when ALU_ARB_CTRL_STATS_EN is defined.
module alu_arb_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [ALU_OP_W-1:0]   req0_op,
  input  logic [ALU_OP_W-1:0]   req1_op,
  input  logic [ALU_DATA_W-1:0] req0_a,
  input  logic [ALU_DATA_W-1:0] req0_b,
  input  logic [ALU_DATA_W-1:0] req1_a,
  input  logic [ALU_DATA_W-1:0] req1_b,
  output logic [ALU_OP_W-1:0]   alu_op,
  output logic [ALU_DATA_W-1:0] alu_a,
  output logic [ALU_DATA_W-1:0] alu_b,
  input  logic [ALU_DATA_W-1:0] alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ALU_DATA_W-1:0] rsp_data,
  output logic                  rsp_id,
  output logic                  busy
`ifdef ALU_ARB_CTRL_STATS_EN
  ,
  output logic [7:0]            grant_cnt0,
  output logic [7:0]            grant_cnt1
`endif
);
  localparam int CNT_W = 3;

  state_t                  state_reg, state_next;
  logic [1:0]              grant;
  logic                    accept;
  logic                    last_grant_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    exec_done;
  logic [ALU_OP_W-1:0]     alu_op_reg;
  logic [ALU_DATA_W-1:0]   alu_a_reg, alu_b_reg;
  logic [ALU_DATA_W-1:0]   rsp_data_reg;
  logic                    rsp_id_reg;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign exec_done = (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Ready is a Mealy pulse on the accept cycle; suppressed while in reset.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst && (grant != 2'b00)) begin
          accept     = 1'b1;
          req0_ready = grant[0];
          req1_ready = grant[1];
          state_next = EXEC;
        end
      end
      EXEC:    if (exec_done) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_reg     <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
    end else if (accept) begin
      alu_op_reg     <= grant[1] ? req1_op : req0_op;
      alu_a_reg      <= grant[1] ? req1_a  : req0_a;
      alu_b_reg      <= grant[1] ? req1_b  : req0_b;
      rsp_id_reg     <= grant[1];
      last_grant_reg <= grant[1];
      cnt_reg        <= CNT_W'(ALU_LAT - 1);
    end else if (state_reg == EXEC) begin
      if (exec_done) rsp_data_reg <= alu_out;
      else           cnt_reg      <= cnt_reg - 1'b1;
    end
  end

  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_valid = (state_reg == RESP);
  assign busy      = (state_reg != IDLE);

`ifdef ALU_ARB_CTRL_STATS_EN
  logic [7:0] grant_cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst) begin
        grant_cnt_reg[gi] <= '0;
      end else if (accept && grant[gi] && (grant_cnt_reg[gi] != 8'hFF)) begin
        grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 8'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt_reg[0];
  assign grant_cnt1 = grant_cnt_reg[1];
`endif
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Bench for alu_arb_ctrl: two instances (ALU_LAT=1 and 4), each with a
// transaction-level reference model checked every cycle plus directed checks.
module tb_alu_arb_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit done [2];

  // Reference ALU used both as the DUT's shared ALU and for expected results.
  function automatic logic [3:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input int inst, input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0d expected %0d", inst, name, act, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 4;

      logic       rst, r0v, r1v, r0r, r1r, rv, rr, rid, busy;
      logic [1:0] r0op, r1op, aop;
      logic [3:0] r0a, r0b, r1a, r1b, aa, ab, aout, rd;
`ifdef ALU_ARB_CTRL_STATS_EN
      logic [7:0] gc0, gc1;
`endif

      assign aout = alu_f(aop, aa, ab);

      alu_arb_ctrl #(.ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req1_valid(r1v),
        .req0_ready(r0r), .req1_ready(r1r),
        .req0_op(r0op), .req1_op(r1op),
        .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
        .alu_op(aop), .alu_a(aa), .alu_b(ab), .alu_out(aout),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_data(rd), .rsp_id(rid),
        .busy(busy)
`ifdef ALU_ARB_CTRL_STATS_EN
        , .grant_cnt0(gc0), .grant_cnt1(gc1)
`endif
      );

      // Transaction model: one outstanding op, timed by cycle arithmetic.
      int         cyc    = 0;
      int         m_acc  = 0;
      bit         m_act  = 0;
      bit         m_last = 1;
      bit         m_id   = 0;
      logic [3:0] m_res  = '0;
      logic [3:0] m_data = '0;
      logic [1:0] m_op   = '0;
      logic [3:0] m_a    = '0;
      logic [3:0] m_b    = '0;

      always @(negedge clk) begin
        bit e_rv, any, w;
        e_rv = m_act && (cyc >= m_acc + LAT + 1);
        any  = !rst && !m_act && (r0v || r1v);
        w    = (r0v && r1v) ? !m_last : r1v;
        check(gi, "m_ready0",  int'(r0r),  int'(any && !w));
        check(gi, "m_ready1",  int'(r1r),  int'(any && w));
        check(gi, "m_busy",    int'(busy), int'(m_act));
        check(gi, "m_rsp_val", int'(rv),   int'(e_rv));
        check(gi, "m_rsp_dat", int'(rd),   int'(m_data));
        check(gi, "m_alu_op",  int'(aop),  int'(m_op));
        check(gi, "m_alu_a",   int'(aa),   int'(m_a));
        check(gi, "m_alu_b",   int'(ab),   int'(m_b));
        if (e_rv) check(gi, "m_rsp_id", int'(rid), int'(m_id));
        if (rst) begin
          m_act = 0; m_last = 1; m_data = '0; m_op = '0; m_a = '0; m_b = '0;
        end else if (any) begin
          m_act  = 1;
          m_acc  = cyc;
          m_id   = w;
          m_last = w;
          m_op   = w ? r1op : r0op;
          m_a    = w ? r1a  : r0a;
          m_b    = w ? r1b  : r0b;
          m_res  = alu_f(m_op, m_a, m_b);
        end else if (m_act && (cyc == m_acc + LAT)) begin
          m_data = m_res;
        end else if (e_rv && rr) begin
          m_act = 0;
          $display("[TB] inst%0d rsp id=%0d data=%h cyc=%0d", gi, m_id, m_data, cyc);
        end
        cyc++;
      end

      task automatic step();
        @(posedge clk);
        #1;
      endtask

      task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
      endtask

      initial begin : stim
        int k;
        int order [$];
        int o0, o1, o2;
        bit g0, g1;
        rst = 1'b1; r0v = 0; r1v = 0; rr = 0;
        r0op = '0; r1op = '0; r0a = '0; r0b = '0; r1a = '0; r1b = '0;
        @(negedge clk);
        check(gi, "rst_busy", int'(busy), 0);
        check(gi, "rst_rsp_data", int'(rd), 0);
        step();
        do_reset(2);

        // Single request: 3 + 4 via req0.
        rr = 1; r0v = 1; r0op = 2'b00; r0a = 4'h3; r0b = 4'h4;
        @(negedge clk);
        check(gi, "single_ready", int'(r0r), 1);
        step(); r0v = 0;
        @(negedge clk);
        check(gi, "single_alu_a", int'(aa), 3);
        check(gi, "single_alu_b", int'(ab), 4);
        k = 1;
        while (!rv && k < 12) begin step(); @(negedge clk); k++; end
        check(gi, "single_latency", k, LAT + 1);
        check(gi, "single_data", int'(rd), 7);
        check(gi, "single_id", int'(rid), 0);
        step();

        // Contention from reset: expect grant order 0, 1, 0.
        do_reset(2);
        r0v = 1; r1v = 1; r0op = 2'b10; r0a = 4'hC; r0b = 4'hA; r1op = 2'b01; r1a = 4'h9; r1b = 4'h2;
        k = 0;
        while (order.size() < 3 && k < 40) begin
          @(negedge clk);
          if (r0r) order.push_back(0);
          if (r1r) order.push_back(1);
          step(); k++;
        end
        r0v = 0; r1v = 0;
        o0 = (order.size() > 0) ? order[0] : -1;
        o1 = (order.size() > 1) ? order[1] : -1;
        o2 = (order.size() > 2) ? order[2] : -1;
        check(gi, "contend_first", o0, 0);
        check(gi, "contend_second", o1, 1);
        check(gi, "contend_third", o2, 0);
        repeat (LAT + 3) step();

        // Backpressure: req1 xor A^5 = F held for 5 cycles, req0 waiting.
        rr = 0; r1v = 1; r1op = 2'b11; r1a = 4'hA; r1b = 4'h5;
        k = 0; @(negedge clk);
        while (!r1r && k < 10) begin step(); @(negedge clk); k++; end
        check(gi, "bp_accept", int'(r1r), 1);
        step(); r1v = 0; r0v = 1; r0op = 2'b10; r0a = 4'hF; r0b = 4'h6;
        k = 0; @(negedge clk);
        while (!rv && k < 10) begin step(); @(negedge clk); k++; end
        for (int i = 0; i < 5; i++) begin
          check(gi, "bp_valid", int'(rv), 1);
          check(gi, "bp_data", int'(rd), 15);
          check(gi, "bp_id", int'(rid), 1);
          check(gi, "bp_busy", int'(busy), 1);
          check(gi, "bp_no_ready0", int'(r0r), 0);
          if (i < 4) begin step(); @(negedge clk); end
        end
        step(); rr = 1;
        k = 0; @(negedge clk);
        while (!r0r && k < 10) begin step(); @(negedge clk); k++; end
        check(gi, "bp_req0_after", int'(r0r), 1);
        step(); r0v = 0;
        repeat (LAT + 3) step();

        // Reset one cycle into EXEC abandons the transaction.
        r0v = 1; r0op = 2'b00; r0a = 4'h5; r0b = 4'h6;
        k = 0; @(negedge clk);
        while (!r0r && k < 10) begin step(); @(negedge clk); k++; end
        step(); r0v = 0;
        rst = 1; step(); rst = 0;
        @(negedge clk);
        check(gi, "rexec_busy", int'(busy), 0);
        check(gi, "rexec_valid", int'(rv), 0);
        check(gi, "rexec_data", int'(rd), 0);
        check(gi, "rexec_alu_a", int'(aa), 0);
        for (int i = 0; i < LAT + 2; i++) begin
          step(); @(negedge clk);
          check(gi, "rexec_no_rsp", int'(rv), 0);
        end
        step();
        r1v = 1; r1op = 2'b01; r1a = 4'h2; r1b = 4'h5;
        k = 0; @(negedge clk);
        while (!r1r && k < 10) begin step(); @(negedge clk); k++; end
        step(); r1v = 0;
        k = 0; @(negedge clk);
        while (!rv && k < 10) begin step(); @(negedge clk); k++; end
        check(gi, "rexec_after_valid", int'(rv), 1);
        check(gi, "rexec_after_id", int'(rid), 1);
        check(gi, "rexec_after_data", int'(rd), 13);
        step();

        // Randomised traffic with occasional resets and backpressure.
        for (int c = 0; c < 1500; c++) begin
          @(negedge clk); g0 = r0r; g1 = r1r;
          step();
          if (g0) r0v = 0;
          if (g1) r1v = 0;
          if (!r0v && $urandom_range(1, 0) == 1) begin
            r0v = 1; r0op = 2'($urandom); r0a = 4'($urandom); r0b = 4'($urandom);
          end
          if (!r1v && $urandom_range(1, 0) == 1) begin
            r1v = 1; r1op = 2'($urandom); r1a = 4'($urandom); r1b = 4'($urandom);
          end
          rr  = ($urandom_range(9, 0) < 7);
          rst = ($urandom_range(199, 0) == 0);
        end
        rst = 0; r0v = 0; r1v = 0; rr = 1;
        repeat (LAT + 4) step();

`ifdef ALU_ARB_CTRL_STATS_EN
        do_reset(2);
        r0v = 1; r0op = 2'b00; r0a = 4'h1; r0b = 4'h1;
        k = 0;
        while (k < 300) begin
          @(negedge clk);
          if (r0r) k++;
          step();
        end
        r0v = 0;
        repeat (LAT + 3) step();
        check(gi, "stats_cnt0", int'(gc0), 255);
        check(gi, "stats_cnt1", int'(gc1), 0);
`endif
        done[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin : finisher
    int waited;
    waited = 0;
    while (!(done[0] && done[1]) && waited < 60000) begin
      @(posedge clk);
      waited++;
    end
    if (!(done[0] && done[1])) begin
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: got %0d done instances expected 2", int'(done[0]) + int'(done[1]));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
